mem_access_unit: RTL and testbench

Parametrised successor to the pass-through MEM stage of the RISC-V core. It accepts one instruction from EX/MEM and either forwards the ALU result or performs a load/store over a narrow, handshaked memory bus. Loads and stores are split into multiple bus beats, and load data is sign- or zero-extended. It stalls the pipeline until the access retires, then presents a registered result to WB.

---
 rtl/mem_access_unit_pkg.sv | 40 ++++
 rtl/mem_access_unit_if.sv | 25 ++
 rtl/mem_access_unit_load_extend.sv | 26 ++
 rtl/mem_access_unit.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the memory access unit.
// Contents: mem_op_t (MEM stage operation), state_t (access FSM states),
// op_bytes() (access size in bytes), is_store(), ZeroWord, NOPRegAddr.
package mem_access_unit_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr = 5'd0;

  function automatic logic [2:0] op_bytes(input mem_op_t op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: op_bytes = 3'd1;
      MEM_LH, MEM_LHU, MEM_SH: op_bytes = 3'd2;
      MEM_LW, MEM_SW:          op_bytes = 3'd4;
      default:                 op_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Narrow handshaked memory bus between the access unit and memory.
// master: the access unit (drives req/we/addr/wdata, receives rdata/ack).
// slave:  the memory side.
// A beat completes on a cycle where mem_req_o and mem_ack_i are both high.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int BUS_W  = 8
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [BUS_W-1:0]  mem_wdata_o;
  logic [BUS_W-1:0]  mem_rdata_i;
  logic              mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load-data extension.
// Ports: op  - load operation selecting width and signedness
//        raw - assembled little-endian load bytes
//        ext - sign/zero extended result (LW passes raw through)
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mem_op_t         op,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] ext
);

  always_comb begin
    ext = raw;
    case (op)
      MEM_LB:  ext = {{(XLEN-8){raw[7]}}, raw[7:0]};
      MEM_LBU: ext = {{(XLEN-8){1'b0}}, raw[7:0]};
      MEM_LH:  ext = {{(XLEN-16){raw[15]}}, raw[15:0]};
      MEM_LHU: ext = {{(XLEN-16){1'b0}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: forwards ALU results or performs loads/stores as multi-beat
// transfers on a narrow memory bus, stalling upstream until retirement.
// Ports: clk, rst (synchronous, active-high)
//        ex_*          : instruction from EX/MEM, ex_ready_o accepts (IDLE only)
//        bus           : mem_access_unit_if.master memory bus
//        stall_o       : !ex_ready_o
//        wb_valid_o, rd_o, wdata_o, wreg_o : registered result to WB
//        exc_o         : misaligned-access pulse
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of masking the low address bits.
//
// state  | meaning
// IDLE   | ready; NONE ops retire here with one-cycle latency
// ACCESS | issuing bus beats, one per ack
// DONE   | result presented to WB next cycle, then back to IDLE
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 32,
  parameter int BUS_W      = 8,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [XLEN-1:0]       wdata_i,
  input  logic                  wreg_i,
  input  mem_op_t               mem_op_i,
  input  logic [XLEN-1:0]       store_data_i,
  mem_access_unit_if.master     bus,
  output logic                  stall_o,
  output logic                  wb_valid_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [XLEN-1:0]       wdata_o,
  output logic                  wreg_o,
  output logic                  exc_o
);

  localparam logic [2:0] BPB     = 3'(BUS_W / 8);
  localparam int         BEAT_SH = $clog2(BUS_W / 8);

  state_t                state_q, state_d;
  mem_op_t               op_q;
  logic [ADDR_W-1:0]     base_q;
  logic [XLEN-1:0]       wdata_q, sdata_q, acc_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  wreg_q, trap_q;
  logic [2:0]            beat_q, beats_q;

  logic                  accept, is_mem, trap_now, beat_done, last_beat;
  logic [2:0]            bytes_in, beats_in;
  logic [1:0]            lowmask;
  logic [ADDR_W-1:0]     addr_in;
  logic [XLEN-1:0]       sdata_in, ext_data;
  logic [7:0]            bit_off;

  logic                  wb_valid_d, wreg_d, exc_d;
  logic [REG_ADDR_W-1:0] rd_d;
  logic [XLEN-1:0]       wdata_d;

  assign accept   = (state_q == ST_IDLE) && ex_valid_i;
  assign is_mem   = (mem_op_i != MEM_NONE);
  assign bytes_in = op_bytes(mem_op_i);
  assign beats_in = (bytes_in > BPB) ? (bytes_in >> BEAT_SH) : 3'd1;
  assign lowmask  = 2'(bytes_in - 3'd1);
  assign addr_in  = ADDR_W'(wdata_i) & ~ADDR_W'(lowmask);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_now = is_mem && ((wdata_i[1:0] & lowmask) != 2'b00);
`else
  assign trap_now = 1'b0;
`endif

  // Narrow stores only carry their own bytes; upper lanes of a wide beat read as zero.
  always_comb begin
    sdata_in = store_data_i;
    case (mem_op_i)
      MEM_SB:  sdata_in = XLEN'(store_data_i[7:0]);
      MEM_SH:  sdata_in = XLEN'(store_data_i[15:0]);
      default: sdata_in = store_data_i;
    endcase
  end

  // Beat k covers bytes [k*BPB +: BPB] of the access, little-endian.
  assign bit_off   = {5'd0, beat_q} << $clog2(BUS_W);
  assign beat_done = (state_q == ST_ACCESS) && bus.mem_ack_i;
  assign last_beat = (beat_q == beats_q - 3'd1);

  assign bus.mem_req_o   = (state_q == ST_ACCESS);
  assign bus.mem_we_o    = (state_q == ST_ACCESS) && is_store(op_q);
  assign bus.mem_addr_o  = base_q + (ADDR_W'(beat_q) << BEAT_SH);
  assign bus.mem_wdata_o = BUS_W'(sdata_q >> bit_off);

  assign ex_ready_o = (state_q == ST_IDLE);
  assign stall_o    = !ex_ready_o;

  mem_access_unit_load_extend #(.XLEN(XLEN)) u_load_extend (
    .op  (op_q),
    .raw (acc_q),
    .ext (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    wb_valid_d = 1'b0;
    rd_d       = rd_o;
    wdata_d    = wdata_o;
    wreg_d     = wreg_o;
    exc_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid_i) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            rd_d       = rd_i;
            wdata_d    = wdata_i;
            wreg_d     = wreg_i;
          end else if (trap_now) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (beat_done && last_beat) state_d = ST_DONE;
      end
      ST_DONE: begin
        wb_valid_d = 1'b1;
        rd_d       = rd_q;
        wdata_d    = (is_store(op_q) || trap_q) ? wdata_q : ext_data;
        wreg_d     = wreg_q && !is_store(op_q) && !trap_q;
        exc_d      = trap_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wb_valid_o <= 1'b0;
      rd_o       <= REG_ADDR_W'(NOPRegAddr);
      wdata_o    <= XLEN'(ZeroWord);
      wreg_o     <= 1'b0;
      exc_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_o <= wb_valid_d;
      rd_o       <= rd_d;
      wdata_o    <= wdata_d;
      wreg_o     <= wreg_d;
      exc_o      <= exc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= MEM_NONE;
      base_q  <= '0;
      wdata_q <= '0;
      sdata_q <= '0;
      acc_q   <= '0;
      rd_q    <= '0;
      wreg_q  <= 1'b0;
      trap_q  <= 1'b0;
      beat_q  <= 3'd0;
      beats_q <= 3'd0;
    end else begin
      if (accept && is_mem) begin
        op_q    <= mem_op_i;
        base_q  <= addr_in;
        wdata_q <= wdata_i;
        sdata_q <= sdata_in;
        acc_q   <= '0;
        rd_q    <= rd_i;
        wreg_q  <= wreg_i;
        trap_q  <= trap_now;
        beat_q  <= 3'd0;
        beats_q <= beats_in;
      end
      if (beat_done) begin
        acc_q <= acc_q | (XLEN'(bus.mem_rdata_i) << bit_off);
        if (!last_beat) beat_q <= beat_q + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid_i, ex_ready_o, wreg_i, stall_o, wb_valid_o, wreg_o, exc_o;
  logic [4:0]  rd_i, rd_o;
  logic [31:0] wdata_i, store_data_i, wdata_o;
  mem_op_t     mem_op_i;

  mem_access_unit_if #(.ADDR_W(32), .BUS_W(8)) bus ();

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid_i   (ex_valid_i),
    .ex_ready_o   (ex_ready_o),
    .rd_i         (rd_i),
    .wdata_i      (wdata_i),
    .wreg_i       (wreg_i),
    .mem_op_i     (mem_op_i),
    .store_data_i (store_data_i),
    .bus          (bus),
    .stall_o      (stall_o),
    .wb_valid_o   (wb_valid_o),
    .rd_o         (rd_o),
    .wdata_o      (wdata_o),
    .wreg_o       (wreg_o),
    .exc_o        (exc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        wreg;
    logic        exc;
    logic        chk_wdata;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
  } beat_exp_t;

  wb_exp_t   wb_q[$];
  beat_exp_t beat_q[$];

  int   vec_cnt = 0, err_cnt = 0;
  int   cyc = 0, wb_cnt = 0, last_wb_cyc = 0, stall_cycles = 0, req_cycles = 0, beats_acked = 0;
  int   ack_delay = 0, wait_cnt = 0;
  logic stray_ack = 1'b0;
  logic [7:0] mem [0:1023];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] wd, input logic wreg,
                           input logic exc, input logic chk);
    wb_exp_t e;
    e.rd = rd; e.wdata = wd; e.wreg = wreg; e.exc = exc; e.chk_wdata = chk;
    wb_q.push_back(e);
  endtask

  task automatic expect_beat(input logic we, input logic [31:0] addr, input logic [7:0] wd);
    beat_exp_t e;
    e.we = we; e.addr = addr; e.wdata = wd;
    beat_q.push_back(e);
  endtask

  // Called at posedge+1; returns the cycle in which the op was presented and accepted.
  task automatic issue(input mem_op_t op, input logic [4:0] rd, input logic [31:0] wd,
                       input logic wreg, input logic [31:0] sd, output int present);
    logic rdy;
    int   n;
    rdy = 1'b0; n = 0; present = 0;
    ex_valid_i = 1'b1; mem_op_i = op; rd_i = rd; wdata_i = wd; wreg_i = wreg; store_data_i = sd;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = ex_ready_o;
      present = cyc;
      @(posedge clk);
      n++;
    end
    #1;
    ex_valid_i = 1'b0; mem_op_i = MEM_NONE;
    if (!rdy) begin
      vec_cnt++; err_cnt++;
      $display("FAIL issue_timeout: ex_ready_o stayed 0, required 1 within 50 cycles");
    end
  endtask

  task automatic wait_wb(input int target);
    int n;
    n = 0;
    while (wb_cnt < target && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    if (wb_cnt < target) begin
      vec_cnt++; err_cnt++;
      $display("FAIL wb_timeout: got %0d retires, required %0d", wb_cnt, target);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // WB monitor / scoreboard.
  always @(negedge clk) begin : wb_mon
    wb_exp_t e;
    if (stall_o) stall_cycles++;
    if (wb_valid_o) begin
      wb_cnt++;
      last_wb_cyc = cyc;
      if (wb_q.size() == 0) begin
        vec_cnt++; err_cnt++;
        $display("FAIL wb_unexpected: got retire rd=%0d wdata=0x%08h, required none", rd_o, wdata_o);
      end else begin
        e = wb_q.pop_front();
        check("wb_rd",   32'(rd_o),   32'(e.rd));
        check("wb_wreg", 32'(wreg_o), 32'(e.wreg));
        check("wb_exc",  32'(exc_o),  32'(e.exc));
        if (e.chk_wdata) check("wb_wdata", wdata_o, e.wdata);
      end
    end
  end

  // Memory slave with programmable ack delay; checks every requesting cycle
  // against the expected beat, so address/data must hold during waits.
  always @(negedge clk) begin : slave
    beat_exp_t e;
    if (rst) begin
      bus.mem_ack_i = 1'b0;
      wait_cnt = 0;
    end else if (bus.mem_req_o) begin
      req_cycles++;
      if (beat_q.size() == 0) begin
        vec_cnt++; err_cnt++;
        $display("FAIL bus_unexpected: got req addr=0x%08h, required no request", bus.mem_addr_o);
      end else begin
        e = beat_q[0];
        check("beat_we",   32'(bus.mem_we_o), 32'(e.we));
        check("beat_addr", bus.mem_addr_o, e.addr);
        if (e.we) check("beat_wdata", 32'(bus.mem_wdata_o), 32'(e.wdata));
        check("beat_stall", 32'(stall_o), 32'd1);
      end
      if (wait_cnt >= ack_delay) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = mem[bus.mem_addr_o[9:0]];
        if (bus.mem_we_o) mem[bus.mem_addr_o[9:0]] = bus.mem_wdata_o;
        wait_cnt = 0;
        beats_acked++;
        if (beat_q.size() != 0) void'(beat_q.pop_front());
      end else begin
        bus.mem_ack_i = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus.mem_ack_i = stray_ack;
      wait_cnt = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int p0, p1, w1, w2, s0, n0, rc, b0, k;
    ex_valid_i = 1'b0; rd_i = '0; wdata_i = '0; wreg_i = 1'b0;
    mem_op_i = MEM_NONE; store_data_i = '0;
    bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h78; mem[10'h101] = 8'h56; mem[10'h102] = 8'h34; mem[10'h103] = 8'h12;
    mem[10'h180] = 8'h80;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req",      32'(bus.mem_req_o),   32'd0);
    check("rst_addr",     bus.mem_addr_o,       32'd0);
    check("rst_wb_valid", 32'(wb_valid_o),      32'd0);
    check("rst_wdata",    wdata_o,              32'd0);
    check("rst_ready",    32'(ex_ready_o),      32'd1);
    @(posedge clk); #1 rst = 1'b0;

    // ALU pass-through, back to back
    s0 = stall_cycles; n0 = wb_cnt;
    expect_wb(5'd5, 32'h1234, 1'b1, 1'b0, 1'b1);
    issue(MEM_NONE, 5'd5, 32'h1234, 1'b1, 32'h0, p0);
    expect_wb(5'd6, 32'h55, 1'b1, 1'b0, 1'b1);
    issue(MEM_NONE, 5'd6, 32'h55, 1'b1, 32'h0, p1);
    wait_wb(n0 + 1); w1 = last_wb_cyc;
    wait_wb(n0 + 2); w2 = last_wb_cyc;
    check("pt_latency",     32'(w1 - p0), 32'd1);
    check("pt_consecutive", 32'(w2 - w1), 32'd1);
    check("pt_no_stall",    32'(stall_cycles - s0), 32'd0);

    // LW 0x100, zero-wait ack
    n0 = wb_cnt;
    for (int i = 0; i < 4; i++) expect_beat(1'b0, 32'h100 + 32'(i), 8'h00);
    expect_wb(5'd7, 32'h12345678, 1'b1, 1'b0, 1'b1);
    issue(MEM_LW, 5'd7, 32'h100, 1'b1, 32'h0, p0);
    wait_wb(n0 + 1);
    check("lw_latency", 32'(last_wb_cyc - p0), 32'd6);

    // LB vs LBU with a 2-cycle ack delay
    ack_delay = 2;
    n0 = wb_cnt;
    expect_beat(1'b0, 32'h180, 8'h00);
    expect_wb(5'd8, 32'hFFFFFF80, 1'b1, 1'b0, 1'b1);
    issue(MEM_LB, 5'd8, 32'h180, 1'b1, 32'h0, p0);
    wait_wb(n0 + 1);
    check("lb_wait_latency", 32'(last_wb_cyc - p0), 32'd5);
    expect_beat(1'b0, 32'h180, 8'h00);
    expect_wb(5'd9, 32'h00000080, 1'b1, 1'b0, 1'b1);
    issue(MEM_LBU, 5'd9, 32'h180, 1'b1, 32'h0, p0);
    wait_wb(n0 + 2);
    ack_delay = 0;

    // SH 0x202: two write beats, wreg forced low
    n0 = wb_cnt;
    expect_beat(1'b1, 32'h202, 8'hDD);
    expect_beat(1'b1, 32'h203, 8'hCC);
    expect_wb(5'd10, 32'h0, 1'b0, 1'b0, 1'b0);
    issue(MEM_SH, 5'd10, 32'h202, 1'b1, 32'hAABBCCDD, p0);
    wait_wb(n0 + 1);
    check("sh_mem_lo", 32'(mem[10'h202]), 32'hDD);
    check("sh_mem_hi", 32'(mem[10'h203]), 32'hCC);

    // SW then LH / LHU read-back
    n0 = wb_cnt;
    expect_beat(1'b1, 32'h300, 8'hEF); expect_beat(1'b1, 32'h301, 8'hBE);
    expect_beat(1'b1, 32'h302, 8'hAD); expect_beat(1'b1, 32'h303, 8'hDE);
    expect_wb(5'd11, 32'h0, 1'b0, 1'b0, 1'b0);
    issue(MEM_SW, 5'd11, 32'h300, 1'b1, 32'hDEADBEEF, p0);
    expect_beat(1'b0, 32'h300, 8'h00); expect_beat(1'b0, 32'h301, 8'h00);
    expect_wb(5'd12, 32'hFFFFBEEF, 1'b1, 1'b0, 1'b1);
    issue(MEM_LH, 5'd12, 32'h300, 1'b1, 32'h0, p0);
    expect_beat(1'b0, 32'h302, 8'h00); expect_beat(1'b0, 32'h303, 8'h00);
    expect_wb(5'd13, 32'h0000DEAD, 1'b1, 1'b0, 1'b1);
    issue(MEM_LHU, 5'd13, 32'h302, 1'b1, 32'h0, p0);
    wait_wb(n0 + 3);

    // Reset during the second beat of an LW
    ack_delay = 2;
    b0 = beats_acked;
    for (int i = 0; i < 4; i++) expect_beat(1'b0, 32'h100 + 32'(i), 8'h00);
    issue(MEM_LW, 5'd14, 32'h100, 1'b1, 32'h0, p0);
    k = 0;
    while (!(bus.mem_req_o && beats_acked == b0 + 1) && k < 30) begin
      @(posedge clk); #2;
      k++;
    end
    check("rstmid_reached_beat1", bus.mem_addr_o, 32'h101);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    beat_q.delete(); wb_q.delete();
    ack_delay = 0;
    @(negedge clk);
    check("rstmid_req",      32'(bus.mem_req_o),     32'd0);
    check("rstmid_we",       32'(bus.mem_we_o),      32'd0);
    check("rstmid_addr",     bus.mem_addr_o,         32'd0);
    check("rstmid_mwdata",   32'(bus.mem_wdata_o),   32'd0);
    check("rstmid_wb_valid", 32'(wb_valid_o),        32'd0);
    check("rstmid_rd",       32'(rd_o),              32'd0);
    check("rstmid_wdata",    wdata_o,                32'd0);
    check("rstmid_wreg",     32'(wreg_o),            32'd0);
    check("rstmid_exc",      32'(exc_o),             32'd0);
    check("rstmid_ready",    32'(ex_ready_o),        32'd1);
    @(posedge clk); #1;
    rc = req_cycles; n0 = wb_cnt;
    stray_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1 stray_ack = 1'b0;
    check("stray_no_req",   32'(req_cycles - rc), 32'd0);
    check("stray_no_wb",    32'(wb_cnt - n0),     32'd0);
    check("stray_ready",    32'(ex_ready_o),      32'd1);
    expect_wb(5'd15, 32'hCAFE, 1'b1, 1'b0, 1'b1);
    issue(MEM_NONE, 5'd15, 32'hCAFE, 1'b1, 32'h0, p0);
    wait_wb(n0 + 1);
    check("after_rst_latency", 32'(last_wb_cyc - p0), 32'd1);

    // Misaligned LW 0x101
    n0 = wb_cnt; rc = req_cycles;
`ifdef MEM_MISALIGN_TRAP_EN
    expect_wb(5'd16, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(MEM_LW, 5'd16, 32'h101, 1'b1, 32'h0, p0);
    wait_wb(n0 + 1);
    check("mis_no_req", 32'(req_cycles - rc), 32'd0);
`else
    for (int i = 0; i < 4; i++) expect_beat(1'b0, 32'h100 + 32'(i), 8'h00);
    expect_wb(5'd16, 32'h12345678, 1'b1, 1'b0, 1'b1);
    issue(MEM_LW, 5'd16, 32'h101, 1'b1, 32'h0, p0);
    wait_wb(n0 + 1);
    check("mis_req_cycles", 32'(req_cycles - rc), 32'd4);
`endif

    repeat (5) @(posedge clk);
    check("drain_wb_queue",   32'(wb_q.size()),   32'd0);
    check("drain_beat_queue", 32'(beat_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
